keypad_scan: RTL

Upstream input stage for the two-digit seven-segment display. Scans a 4x4 matrix hex keypad, synchronizes and debounces the row inputs, and decodes each new key press into a 4-bit hex code. The two most recent codes are held as `digit_new` and `digit_old`; they drive the display block's two 4-bit digit inputs in place of the DIP switches.

---
 rtl/keypad_scan_if.sv | 28 ++
 rtl/keypad_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: matrix drive/sense pins and decoded digit outputs.
// Ports: rows (keypad sense, active-low), cols (column drive, active-low),
//        digit_new / digit_old (last two accepted codes), key_valid (accept pulse).
interface keypad_scan_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_valid;

  // master: the scanner itself
  modport master (
    input  rows,
    output cols,
    output digit_new,
    output digit_old,
    output key_valid
  );

  // slave: keypad matrix / display side
  modport slave (
    output rows,
    input  cols,
    input  digit_new,
    input  digit_old,
    input  key_valid
  );
endinterface

// File: rtl/keypad_scan.sv
// Purpose: scans a 4x4 hex keypad, debounces one key at a time, keeps the last two codes.
// Latency: rows -> decision 2 cycles (synchronizer); key_valid exactly DEBOUNCE_CYCLES after debounce entry.
// Backpressure: none; key_valid is a fire-and-forget pulse, digits hold until the next accept.
// Ports: clk, reset (async, active-high); kp.rows in (active-low), kp.cols out (one bit low),
//        kp.digit_new / kp.digit_old out (registered codes), kp.key_valid out (1-cycle pulse).
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Terminal counts: both counters run 0..N-1 and act on the N-th cycle.
  localparam logic [SCW-1:0] SC_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  // Row-by-column key map of the hex pad.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Registered state
  state_e         state_q, state_d;
  logic [3:0]     sync1_q, sync2_q;
  logic [1:0]     col_idx_q, col_idx_d;
  logic [1:0]     row_idx_q, row_idx_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]     cols_q, cols_d;
  logic [3:0]     digit_new_q, digit_new_d;
  logic [3:0]     digit_old_q, digit_old_d;
  logic           key_valid_q, key_valid_d;

  // Decode of the synchronized rows
  logic [3:0]     rs_low;
  logic           one_low;
  logic [1:0]     low_row;
  logic           row_high;

  // Rows are asynchronous to clk; the flops reset to "no key" so a press
  // held across reset is seen cleanly as a new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= kp.rows;
      sync2_q <= sync1_q;
    end
  end

  // Exactly one row low is a candidate key; zero or several rows low is
  // treated as "nothing usable" so ghosting never produces an accept.
  always_comb begin
    rs_low  = ~sync2_q;
    one_low = 1'b1;
    low_row = 2'd0;
    case (rs_low)
      4'b0001: low_row = 2'd0;
      4'b0010: low_row = 2'd1;
      4'b0100: low_row = 2'd2;
      4'b1000: low_row = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Only the latched row matters once a key is being tracked; other rows of
  // the same column are deliberately ignored.
  assign row_high = sync2_q[row_idx_q];

  // Next-state logic. Counters default to zero, so any state change clears
  // them and they only advance while staying in the same state.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    scan_cnt_d  = '0;
    db_cnt_d    = '0;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    key_valid_d = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SC_LAST) begin
          // Slot end: the column has been driven long enough for the
          // synchronizer to show its rows.
          if (one_low) begin
            row_idx_d = low_row;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (row_high) begin
          // Bounce, including on the final cycle: abandon and move on.
          state_d   = ST_SCAN;
          col_idx_d = col_idx_q + 2'd1;
        end else if (db_cnt_q == DB_LAST) begin
          digit_old_d = digit_new_q;
          digit_new_d = key_code(row_idx_q, col_idx_q);
          key_valid_d = 1'b1;
          state_d     = ST_HELD;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      ST_HELD: begin
        if (row_high) begin
          state_d = ST_RELEASE;
        end
      end

      default: begin // ST_RELEASE
        if (row_high) begin
          if (db_cnt_q == DB_LAST) begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        // A low reading leaves db_cnt_d at its zero default: restart the count.
      end
    endcase

    // Column drive is registered from the next column index so the pins
    // change glitch-free on the same edge as the index.
    cols_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      cols_q      <= 4'b1110;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      cols_q      <= cols_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.cols      = cols_q;
  assign kp.digit_new = digit_new_q;
  assign kp.digit_old = digit_old_q;
  assign kp.key_valid = key_valid_q;

endmodule
